// File: rtl/i2c_slave_word_endpoint.sv
// Addressed I2C slave that assembles written bytes into DATA_WIDTH words and
// serialises core-supplied words back to the master on reads.
module i2c_slave_word_endpoint #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         I2C_DATA_WIDTH = 8,
  parameter logic [6:0] SLAVE_ADDR     = 7'h2A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  input  logic [DATA_WIDTH-1:0] tx_word,
  output logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_word,
  output logic                  rx_valid,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / I2C_DATA_WIDTH;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int BW    = $clog2(((I2C_DATA_WIDTH > 8) ? I2C_DATA_WIDTH : 8) + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);
  localparam logic [BW-1:0] ADDR_BITS = BW'(8);
  localparam logic [BW-1:0] DATA_BITS = BW'(I2C_DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK
  } state_t;

  state_t                state;
  logic [1:0]            scl_q, sda_q;
  logic                  scl_d, sda_d;
  logic                  sda_oe;
  logic [BW-1:0]         bit_cnt;
  logic [CW-1:0]         byte_cnt;
  logic [7:0]            addr_shift;
  logic                  rw;
  logic [DATA_WIDTH-1:0] word_shift;
  logic [DATA_WIDTH-1:0] tx_shift;

  // Open-drain: the endpoint only ever pulls low or lets go.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  wire scl_s      = scl_q[1];
  wire sda_s      = sda_q[1];
  wire scl_rise   = scl_s & ~scl_d;
  wire scl_fall   = ~scl_s & scl_d;
  wire start_cond = scl_s & scl_d & sda_d & ~sda_s;
  wire stop_cond  = scl_s & scl_d & ~sda_d & sda_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_q <= 2'b11;
      sda_q <= 2'b11;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= {scl_q[0], scl};
      sda_q <= {sda_q[0], sda};
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sda_oe     <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      addr_shift <= '0;
      rw         <= 1'b0;
      word_shift <= '0;
      tx_shift   <= '0;
      rx_word    <= '0;
      rx_valid   <= 1'b0;
      tx_load    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      tx_load  <= 1'b0;
      rx_valid <= 1'b0;
      if (start_cond) begin
        state    <= ADDR;
        sda_oe   <= 1'b0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (stop_cond) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        byte_cnt <= '0;
      end else begin
        case (state)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              addr_shift <= {addr_shift[6:0], sda_s};
              bit_cnt    <= bit_cnt + 1'b1;
            end else if (scl_fall && bit_cnt == ADDR_BITS) begin
              if (addr_shift[7:1] == SLAVE_ADDR) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= addr_shift[0];
                state  <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt  <= '0;
              byte_cnt <= '0;
              if (rw) begin
                tx_shift <= {tx_word[DATA_WIDTH-2:0], 1'b0};
                sda_oe   <= ~tx_word[DATA_WIDTH-1];
                tx_load  <= 1'b1;
                state    <= TX_BYTE;
              end else begin
                sda_oe <= 1'b0;
                state  <= RX_BYTE;
              end
            end
          end
          RX_BYTE: begin
            if (scl_rise) begin
              word_shift <= {word_shift[DATA_WIDTH-2:0], sda_s};
              bit_cnt    <= bit_cnt + 1'b1;
            end else if (scl_fall && bit_cnt == DATA_BITS) begin
              sda_oe  <= 1'b1;
              bit_cnt <= '0;
              state   <= RX_ACK;
            end
          end
          RX_ACK: begin
            // The first byte of a word has shifted up into the MSBs by the time the counter wraps.
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= RX_BYTE;
              if (byte_cnt == LAST_BYTE) begin
                byte_cnt <= '0;
                rx_word  <= word_shift;
                rx_valid <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end
          TX_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt == DATA_BITS) begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= TX_ACK;
              end else begin
                sda_oe   <= ~tx_shift[DATA_WIDTH-1];
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          TX_ACK: begin
            if (scl_rise && sda_s) begin
              busy     <= 1'b0;
              byte_cnt <= '0;
              state    <= IDLE;
            end else if (scl_fall) begin
              state <= TX_BYTE;
              if (byte_cnt == LAST_BYTE) begin
                byte_cnt <= '0;
                tx_shift <= {tx_word[DATA_WIDTH-2:0], 1'b0};
                sda_oe   <= ~tx_word[DATA_WIDTH-1];
                tx_load  <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
                sda_oe   <= ~tx_shift[DATA_WIDTH-1];
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_word_endpoint.sv
// Directed bench: a bit-banged I2C master drives the endpoint, expected words and
// bytes go through scoreboards and every comparison is an immediate assertion.
module tb_i2c_slave_word_endpoint;

  logic        clk;
  logic        rst;
  logic        scl;
  logic        m_sda_low;
  logic [31:0] tx_word;
  logic        tx_load;
  logic [31:0] rx_word;
  logic        rx_valid;
  logic        busy;
  wire         sda;

  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  int tx_loads = 0;
  bit slave_low_seen = 0;
  bit busy_seen = 0;
  logic [31:0] rx_exp[$];
  logic [7:0]  tx_exp[$];
  logic [31:0] rx_model = 32'h0;
  logic        ack;
  logic [7:0]  rd;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_word_endpoint #(
    .DATA_WIDTH(32), .I2C_DATA_WIDTH(8), .SLAVE_ADDR(7'h2A)
  ) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .tx_word(tx_word), .tx_load(tx_load),
    .rx_word(rx_word), .rx_valid(rx_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not reach the end within 2ms");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Scoreboard side: every rx_valid pulse must match the oldest queued word.
  always @(negedge clk) begin
    if (rst && (rx_valid || tx_load))
      check_output("rx_valid_tx_load_exclusive", {31'b0, rx_valid & tx_load}, 32'h0);
    if (rst && rx_valid) begin
      rx_count++;
      check_output("rx_pending", {31'b0, rx_exp.size() > 0}, 32'h1);
      if (rx_exp.size() > 0) begin
        rx_model = rx_exp.pop_front();
        check_output("rx_word_at_valid", rx_word, rx_model);
      end
    end
    if (rst && tx_load) tx_loads++;
    if (sda === 1'b0 && !m_sda_low) slave_low_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    if (!scl) begin
      wait_clk(6);
      m_sda_low = 1'b0;
      wait_clk(6);
      scl = 1'b1;
      wait_clk(12);
    end
    m_sda_low = 1'b1;
    wait_clk(12);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(6);
    m_sda_low = 1'b1;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(6);
    m_sda_low = 1'b0;
    wait_clk(12);
  endtask

  task automatic write_bit(input logic b);
    wait_clk(6);
    m_sda_low = ~b;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(12);
    scl = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    wait_clk(6);
    m_sda_low = 1'b0;
    wait_clk(6);
    scl = 1'b1;
    wait_clk(6);
    b = sda;
    wait_clk(6);
    scl = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(a);
    check_output(tag, {31'b0, a}, {31'b0, exp_ack});
  endtask

  task automatic read_byte(input logic nack, input string tag);
    logic       b;
    logic [7:0] v;
    logic [7:0] e;
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(nack);
    e = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'hxx;
    check_output(tag, {24'b0, v}, {24'b0, e});
  endtask

  initial begin
    int base_rx;
    int base_tx;
    scl = 1'b1;
    m_sda_low = 1'b0;
    tx_word = 32'h0;
    rst = 1'b0;
    wait_clk(5);
    check_output("reset_sda", {31'b0, sda}, 32'h1);
    check_output("reset_rx_word", rx_word, 32'h0);
    check_output("reset_rx_valid", {31'b0, rx_valid}, 32'h0);
    check_output("reset_tx_load", {31'b0, tx_load}, 32'h0);
    check_output("reset_busy", {31'b0, busy}, 32'h0);
    rst = 1'b1;
    wait_clk(10);

    $display("[TB] full word write to 0x2A");
    rx_exp.push_back(32'hA1B1C1D1);
    i2c_start();
    apply_stimulus(8'h54, 1'b0, "w1_addr_ack");
    apply_stimulus(8'hA1, 1'b0, "w1_ack0");
    apply_stimulus(8'hB1, 1'b0, "w1_ack1");
    apply_stimulus(8'hC1, 1'b0, "w1_ack2");
    apply_stimulus(8'hD1, 1'b0, "w1_ack3");
    check_output("w1_busy_before_stop", {31'b0, busy}, 32'h1);
    i2c_stop();
    check_output("w1_busy_after_stop", {31'b0, busy}, 32'h0);
    check_output("w1_rx_count", rx_count, 1);
    check_output("w1_rx_word", rx_word, 32'hA1B1C1D1);

    $display("[TB] write to foreign address 0x2B");
    slave_low_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    apply_stimulus(8'h56, 1'b1, "w2_addr_nack");
    apply_stimulus(8'h55, 1'b1, "w2_data_nack");
    i2c_stop();
    check_output("w2_sda_never_low", {31'b0, slave_low_seen}, 32'h0);
    check_output("w2_busy_never", {31'b0, busy_seen}, 32'h0);
    check_output("w2_rx_count", rx_count, 1);
    check_output("w2_rx_word", rx_word, 32'hA1B1C1D1);

    $display("[TB] four-byte read ending in NACK");
    tx_word = 32'hA2B2C2D2;
    base_tx = tx_loads;
    tx_exp.push_back(8'hA2);
    tx_exp.push_back(8'hB2);
    tx_exp.push_back(8'hC2);
    tx_exp.push_back(8'hD2);
    i2c_start();
    apply_stimulus(8'h55, 1'b0, "r1_addr_ack");
    read_byte(1'b0, "r1_byte0");
    read_byte(1'b0, "r1_byte1");
    read_byte(1'b0, "r1_byte2");
    read_byte(1'b1, "r1_byte3");
    wait_clk(8);
    check_output("r1_busy_after_nack", {31'b0, busy}, 32'h0);
    check_output("r1_sda_released", {31'b0, sda}, 32'h1);
    check_output("r1_tx_loads", tx_loads - base_tx, 1);
    i2c_stop();

    $display("[TB] partial write discarded, then full write");
    base_rx = rx_count;
    i2c_start();
    apply_stimulus(8'h54, 1'b0, "w3_addr_ack");
    apply_stimulus(8'hA1, 1'b0, "w3_ack0");
    apply_stimulus(8'hB1, 1'b0, "w3_ack1");
    i2c_stop();
    check_output("w3_partial_no_valid", rx_count - base_rx, 0);
    rx_exp.push_back(32'h11223344);
    i2c_start();
    apply_stimulus(8'h54, 1'b0, "w4_addr_ack");
    apply_stimulus(8'h11, 1'b0, "w4_ack0");
    apply_stimulus(8'h22, 1'b0, "w4_ack1");
    apply_stimulus(8'h33, 1'b0, "w4_ack2");
    apply_stimulus(8'h44, 1'b0, "w4_ack3");
    i2c_stop();
    check_output("w4_rx_count", rx_count - base_rx, 1);
    check_output("w4_rx_word", rx_word, 32'h11223344);

    $display("[TB] write then repeated START read");
    base_rx = rx_count;
    base_tx = tx_loads;
    tx_word = 32'h01020304;
    tx_exp.push_back(8'h01);
    i2c_start();
    apply_stimulus(8'h54, 1'b0, "rs_wr_addr_ack");
    apply_stimulus(8'hAA, 1'b0, "rs_wr_ack");
    i2c_start();
    apply_stimulus(8'h55, 1'b0, "rs_rd_addr_ack");
    read_byte(1'b1, "rs_byte0");
    wait_clk(8);
    check_output("rs_busy_idle", {31'b0, busy}, 32'h0);
    i2c_stop();
    check_output("rs_no_rx_valid", rx_count - base_rx, 0);
    check_output("rs_tx_loads", tx_loads - base_tx, 1);
    check_output("rs_rx_word_held", rx_word, 32'h11223344);

    $display("[TB] reset asserted mid-read");
    tx_word = 32'h0F000000;
    i2c_start();
    apply_stimulus(8'h55, 1'b0, "rr_addr_ack");
    read_bit(ack);
    read_bit(ack);
    wait_clk(8);
    check_output("rr_sda_driven_low", {31'b0, sda}, 32'h0);
    rst = 1'b0;
    #1;
    check_output("rr_sda_released_now", {31'b0, sda}, 32'h1);
    check_output("rr_busy", {31'b0, busy}, 32'h0);
    check_output("rr_rx_word", rx_word, 32'h0);
    check_output("rr_rx_valid", {31'b0, rx_valid}, 32'h0);
    check_output("rr_tx_load", {31'b0, tx_load}, 32'h0);
    wait_clk(4);
    scl = 1'b1;
    wait_clk(6);
    rst = 1'b1;
    wait_clk(12);
    base_rx = rx_count;
    rx_exp.push_back(32'h01234567);
    i2c_start();
    apply_stimulus(8'h54, 1'b0, "rw_addr_ack");
    apply_stimulus(8'h01, 1'b0, "rw_ack0");
    apply_stimulus(8'h23, 1'b0, "rw_ack1");
    apply_stimulus(8'h45, 1'b0, "rw_ack2");
    apply_stimulus(8'h67, 1'b0, "rw_ack3");
    i2c_stop();
    check_output("rw_rx_count", rx_count - base_rx, 1);
    check_output("rw_rx_word", rx_word, 32'h01234567);
    check_output("rx_queue_drained", rx_exp.size(), 0);
    check_output("tx_queue_drained", tx_exp.size(), 0);

    wait_clk(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
